// File: rtl/demux5_skid.sv
// demux5_skid: registered 1-to-5 valid/ready demux, one holding slot per output.
// Optional macro DEMUX_SEL_CHECK_EN: drop sel 5..7 beats and flag err_sel.
module demux5_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [4:0]       out_valid,
    input  logic [4:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [WIDTH-1:0] out_data4,
    output logic             err_sel
);

    logic [4:0]       tgt_oh;
    logic             sel_bad;
    logic [4:0]       slot_free;
    logic             accept;
    logic [4:0]       load;
    logic [WIDTH-1:0] slot_q [5];

    // Decode in_sel to a one-hot target; s[2] dominates the low bits.
    always_comb begin
        tgt_oh  = 5'b00000;
        sel_bad = 1'b0;
        unique case (1'b1)
            in_sel[2] & (in_sel[1:0] == 2'd0): tgt_oh = 5'b10000;
            in_sel[2] & (in_sel[1:0] != 2'd0): begin
`ifdef DEMUX_SEL_CHECK_EN
                sel_bad = 1'b1;
`else
                tgt_oh  = 5'b10000;
`endif
            end
            ~in_sel[2] & (in_sel[1:0] == 2'd0): tgt_oh = 5'b00001;
            ~in_sel[2] & (in_sel[1:0] == 2'd1): tgt_oh = 5'b00010;
            ~in_sel[2] & (in_sel[1:0] == 2'd2): tgt_oh = 5'b00100;
            ~in_sel[2] & (in_sel[1:0] == 2'd3): tgt_oh = 5'b01000;
            default: tgt_oh = 5'b00000;
        endcase
    end

    // A slot can take a beat if empty or draining this cycle.
    assign slot_free = ~out_valid | out_ready;

    // Illegal selects are swallowed, so they never stall the producer.
    assign in_ready = sel_bad | (|(tgt_oh & slot_free));
    assign accept   = in_valid & in_ready;
    assign load     = tgt_oh & {5{accept}};

    // Slot valid: set on load, cleared on drain, held while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 5'b00000;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_slot
            // Slot payload: capture on load, otherwise keep last beat.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_q[g] <= '0;
                end else if (load[g]) begin
                    slot_q[g] <= in_data;
                end
            end
        end
    endgenerate

    assign out_data0 = slot_q[0];
    assign out_data1 = slot_q[1];
    assign out_data2 = slot_q[2];
    assign out_data3 = slot_q[3];
    assign out_data4 = slot_q[4];

`ifdef DEMUX_SEL_CHECK_EN
    // Sticky flag: any beat offered with an illegal select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sel <= 1'b0;
        end else if (in_valid & sel_bad) begin
            err_sel <= 1'b1;
        end
    end
`else
    assign err_sel = 1'b0;
`endif

endmodule

// File: tb/tb_demux5_skid.sv
// tb_demux5_skid: directed and random checks of demux5_skid against
// a per-slot reference model with ordering scoreboard.
module tb_demux5_skid;

    localparam int W = 32;
`ifdef DEMUX_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic [W-1:0] in_data;
    logic [4:0]   out_valid;
    logic [4:0]   out_ready;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3, out_data4;
    logic         err_sel;
    logic [W-1:0] dq [5];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           mv [5];
    logic [W-1:0] md [5];
    bit           merr;
    logic [W-1:0] fifo [5][64];
    int           wr [5];
    int           rd [5];

    demux5_skid #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .out_data4(out_data4), .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    assign dq[0] = out_data0;
    assign dq[1] = out_data1;
    assign dq[2] = out_data2;
    assign dq[3] = out_data3;
    assign dq[4] = out_data4;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tgt(input logic [2:0] s);
        return s[2] ? 4 : int'(s[1:0]);
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        int t;
        bit bad;
        bit rdy;
        logic [4:0] ev;
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                mv[i] = 1'b0;
                md[i] = '0;
                wr[i] = 0;
                rd[i] = 0;
            end
            merr = 1'b0;
        end
        t   = tgt(in_sel);
        bad = CHK && (in_sel > 3'd4);
        rdy = bad || !mv[t] || out_ready[t];
        for (int i = 0; i < 5; i++) ev[i] = mv[i];
        chk("out_valid", 32'(out_valid), 32'(ev));
        for (int i = 0; i < 5; i++)
            chk($sformatf("out_data%0d", i), dq[i], md[i]);
        chk("err_sel", 32'(err_sel), 32'(merr));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (reset_n) begin
            for (int i = 0; i < 5; i++) begin
                if (mv[i] && out_ready[i]) begin
                    chk($sformatf("sb_pending%0d", i), 32'(wr[i] > rd[i]), 32'd1);
                    if (wr[i] > rd[i]) begin
                        chk($sformatf("sb_order%0d", i), dq[i], fifo[i][rd[i] % 64]);
                        rd[i]++;
                    end
                    mv[i] = 1'b0;
                end
            end
            if (in_valid && rdy) begin
                if (bad) begin
                    merr = 1'b1;
                end else begin
                    mv[t] = 1'b1;
                    md[t] = in_data;
                    fifo[t][wr[t] % 64] = in_data;
                    wr[t]++;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = '0;
        out_ready = 5'b11111;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err_sel), 32'd0);
        chk("rst_data0", out_data0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: one beat per slot, all sinks ready
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 32'hA0 + 32'(i));
            #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
            step();
            chk("t1_valid", 32'(out_valid), 32'd1 << i);
            chk("t1_data", dq[i], 32'hA0 + 32'(i));
        end
        drive(1'b0, 3'd0, 32'd0);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: stalled slot 2 blocks its second beat, then load+drain same cycle
        out_ready = 5'b11011;
        drive(1'b1, 3'd2, 32'h11);
        step();
        chk("t2_valid", 32'(out_valid), 32'b00100);
        chk("t2_data", out_data2, 32'h11);
        drive(1'b1, 3'd2, 32'h22);
        #1 chk("t2_blocked", 32'(in_ready), 32'd0);
        step();
        chk("t2_hold", out_data2, 32'h11);
        out_ready = 5'b11111;
        #1 chk("t2_unblock", 32'(in_ready), 32'd1);
        step();
        chk("t2_swap_v", 32'(out_valid), 32'b00100);
        chk("t2_swap_d", out_data2, 32'h22);
        drive(1'b0, 3'd0, 32'd0);
        step();
        chk("t2_empty", 32'(out_valid), 32'd0);

        // 3: stalled slot 2 does not block slot 3
        out_ready = 5'b11011;
        drive(1'b1, 3'd2, 32'h44);
        step();
        drive(1'b1, 3'd3, 32'h33);
        #1 chk("t3_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("t3_valid", 32'(out_valid), 32'b01100);
        chk("t3_data3", out_data3, 32'h33);
        chk("t3_data2", out_data2, 32'h44);
        drive(1'b0, 3'd0, 32'd0);
        step();
        chk("t3_left", 32'(out_valid), 32'b00100);

        // 4: async reset discards held beats immediately
        out_ready = 5'b00000;
        drive(1'b1, 3'd0, 32'hDEAD);
        step();
        drive(1'b1, 3'd4, 32'hBEEF);
        step();
        drive(1'b0, 3'd0, 32'd0);
        chk("t4_full", 32'(out_valid), 32'b10101);
        chk("t4_d4", out_data4, 32'hBEEF);
        #2 reset_n = 1'b0;
        #1;
        chk("t4_rst_v", 32'(out_valid), 32'd0);
        chk("t4_rst_d0", out_data0, 32'd0);
        chk("t4_rst_d4", out_data4, 32'd0);
        step();
        step();
        reset_n   = 1'b1;
        out_ready = 5'b11111;

        // 5: alias / illegal select
        drive(1'b1, 3'd6, 32'h77);
        #1 chk("t5_in_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 3'd0, 32'd0);
`ifdef DEMUX_SEL_CHECK_EN
        chk("t5_drop", 32'(out_valid), 32'd0);
        chk("t5_err", 32'(err_sel), 32'd1);
        step();
        step();
        chk("t5_sticky", 32'(err_sel), 32'd1);
`else
        chk("t5_alias_v", 32'(out_valid), 32'b10000);
        chk("t5_alias_d", out_data4, 32'h77);
        chk("t5_err", 32'(err_sel), 32'd0);
        step();
`endif

        // 6: random traffic against the model
        for (int n = 0; n < 10000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 3'($urandom_range(0, 7));
            in_data  = $urandom;
            for (int i = 0; i < 5; i++)
                out_ready[i] = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 3'd0, 32'd0);
        out_ready = 5'b11111;
        step();
        step();
        chk("end_drained", 32'(out_valid), 32'd0);
        reset_n = 1'b0;
        #1 chk("end_err_clr", 32'(err_sel), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
